// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : game_pkg
//  Purpose  : Shared action-state encodings and default frame counts for the
//             player action state machine and its helpers.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int unsigned c_STATE_W = 3;

    // Action-state encodings. Code 7 is unused and falls back to IDLE.
    localparam logic [c_STATE_W-1:0] c_ST_IDLE     = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_WALK     = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_BLOCK    = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_WINDUP   = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_ACTIVE   = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_RECOVERY = 3'd5;
    localparam logic [c_STATE_W-1:0] c_ST_HITSTUN  = 3'd6;

    // Default frame counts; each must be >= 1 and < 2**CNT_W.
    localparam int unsigned c_WINDUP_FRAMES_DEF   = 4;
    localparam int unsigned c_ACTIVE_FRAMES_DEF   = 3;
    localparam int unsigned c_RECOVERY_FRAMES_DEF = 6;
    localparam int unsigned c_HITSTUN_FRAMES_DEF  = 10;
    localparam int unsigned c_CNT_W_DEF           = 4;

endpackage : game_pkg
`default_nettype wire

// File: rtl/edge_latch.sv
`default_nettype none
// ============================================================================
//  Module   : edge_latch
//  Purpose  : Event detector plus a pending flag that holds the event until
//             the next frame tick. RISING_EDGE=1 turns a level input into a
//             0->1 edge event; RISING_EDGE=0 treats the input as a pulse.
//  Ports    : clk        - system clock
//             rst        - synchronous active-high reset
//             i_level    - button level or one-cycle pulse input
//             i_tick     - frame strobe; clears the pending flag
//             o_pend_now - pending flag OR an event arriving this cycle, so
//                          an event coincident with the tick is still seen
//  Revision : 1.0 - initial release
// ============================================================================
module edge_latch #(
    parameter bit RISING_EDGE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    input  logic i_tick,
    output logic o_pend_now
);

    logic w_event;
    logic r_pend;

    generate
        if (RISING_EDGE) begin : g_rising
            logic r_prev;
            logic r_armed;

            // r_prev is forced to 0 in reset; r_armed suppresses the first
            // post-reset cycle so a button already held at reset release is
            // not mistaken for a fresh press.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_prev  <= 1'b0;
                    r_armed <= 1'b0;
                end else begin
                    r_prev  <= i_level;
                    r_armed <= 1'b1;
                end
            end

            assign w_event = i_level & ~r_prev & r_armed;
        end else begin : g_level
            assign w_event = i_level;
        end
    endgenerate

    // Every tick consumes the flag, whether or not the FSM acted on it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 1'b0;
        end else if (i_tick) begin
            r_pend <= 1'b0;
        end else if (w_event) begin
            r_pend <= 1'b1;
        end
    end

    assign o_pend_now = r_pend | w_event;

endmodule : edge_latch
`default_nettype wire

// File: rtl/player_action_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : player_action_fsm
//  Purpose  : Fighting-game player action state machine. Button presses and
//             opponent hits are latched between frame ticks and acted on at
//             the tick; attack and hitstun phases are timed in frames.
//  Ports    : clock         - system clock
//             reset         - synchronous active-high reset
//             frame_tick    - one-cycle game-frame strobe
//             btn_left/right/attack/block - debounced button levels
//             hit_in        - one-cycle pulse, opponent hitbox overlap
//             state         - current action state (see game_pkg)
//             move_dir      - {left,right} walk request, 00 outside WALK
//             hitbox_active - high while in ACTIVE
//             attack_start  - one-cycle pulse on WINDUP entry
//             busy          - WINDUP, ACTIVE, RECOVERY or HITSTUN
//  Revision : 1.0 - initial release
// ============================================================================
module player_action_fsm
    import game_pkg::*;
#(
    parameter int unsigned WINDUP_FRAMES   = c_WINDUP_FRAMES_DEF,
    parameter int unsigned ACTIVE_FRAMES   = c_ACTIVE_FRAMES_DEF,
    parameter int unsigned RECOVERY_FRAMES = c_RECOVERY_FRAMES_DEF,
    parameter int unsigned HITSTUN_FRAMES  = c_HITSTUN_FRAMES_DEF,
    parameter int unsigned CNT_W           = c_CNT_W_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    input  logic       btn_block,
    input  logic       hit_in,
    output logic [2:0] state,
    output logic [1:0] move_dir,
    output logic       hitbox_active,
    output logic       attack_start,
    output logic       busy
);

    // Counter load values: a state lasting N frames loads N-1 and leaves
    // on the tick that finds the counter at 0.
    localparam logic [CNT_W-1:0] c_WINDUP_LOAD   = CNT_W'(WINDUP_FRAMES - 1);
    localparam logic [CNT_W-1:0] c_ACTIVE_LOAD   = CNT_W'(ACTIVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] c_RECOVERY_LOAD = CNT_W'(RECOVERY_FRAMES - 1);
    localparam logic [CNT_W-1:0] c_HITSTUN_LOAD  = CNT_W'(HITSTUN_FRAMES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE       = CNT_W'(1);

    logic [c_STATE_W-1:0] r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [1:0]           r_move_dir, w_move_dir_nxt;
    logic                 r_attack_start, w_attack_start_nxt;
    logic                 w_atk;
    logic                 w_hit;

    edge_latch #(.RISING_EDGE(1'b1)) u_attack_latch (
        .clk        (clock),
        .rst        (reset),
        .i_level    (btn_attack),
        .i_tick     (frame_tick),
        .o_pend_now (w_atk)
    );

    edge_latch #(.RISING_EDGE(1'b0)) u_hit_latch (
        .clk        (clock),
        .rst        (reset),
        .i_level    (hit_in),
        .i_tick     (frame_tick),
        .o_pend_now (w_hit)
    );

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_move_dir_nxt     = r_move_dir;
        w_attack_start_nxt = 1'b0;

        if (frame_tick) begin
            w_move_dir_nxt = 2'b00;
            case (r_state)
                c_ST_IDLE, c_ST_WALK, c_ST_BLOCK: begin
                    w_cnt_nxt = '0;
                    // A hit while blocking is simply ignored.
                    if (w_hit && (r_state != c_ST_BLOCK)) begin
                        w_state_nxt = c_ST_HITSTUN;
                        w_cnt_nxt   = c_HITSTUN_LOAD;
                    end else if (w_atk) begin
                        w_state_nxt        = c_ST_WINDUP;
                        w_cnt_nxt          = c_WINDUP_LOAD;
                        w_attack_start_nxt = 1'b1;
                    end else if (btn_block) begin
                        w_state_nxt = c_ST_BLOCK;
                    end else if (btn_left ^ btn_right) begin
                        w_state_nxt    = c_ST_WALK;
                        w_move_dir_nxt = {btn_left, btn_right};
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end

                // Attack presses are dropped here; only a hit interrupts.
                c_ST_WINDUP, c_ST_ACTIVE, c_ST_RECOVERY: begin
                    if (w_hit) begin
                        w_state_nxt = c_ST_HITSTUN;
                        w_cnt_nxt   = c_HITSTUN_LOAD;
                    end else if (r_cnt == '0) begin
                        case (r_state)
                            c_ST_WINDUP: begin
                                w_state_nxt = c_ST_ACTIVE;
                                w_cnt_nxt   = c_ACTIVE_LOAD;
                            end
                            c_ST_ACTIVE: begin
                                w_state_nxt = c_ST_RECOVERY;
                                w_cnt_nxt   = c_RECOVERY_LOAD;
                            end
                            default: begin
                                w_state_nxt = c_ST_IDLE;
                                w_cnt_nxt   = '0;
                            end
                        endcase
                    end else begin
                        w_cnt_nxt = r_cnt - c_CNT_ONE;
                    end
                end

                // A fresh hit restarts the full hitstun period.
                c_ST_HITSTUN: begin
                    if (w_hit) begin
                        w_cnt_nxt = c_HITSTUN_LOAD;
                    end else if (r_cnt == '0) begin
                        w_state_nxt = c_ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - c_CNT_ONE;
                    end
                end

                default: begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_cnt          <= '0;
            r_move_dir     <= 2'b00;
            r_attack_start <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_move_dir     <= w_move_dir_nxt;
            r_attack_start <= w_attack_start_nxt;
        end
    end

    assign state         = r_state;
    assign move_dir      = r_move_dir;
    assign attack_start  = r_attack_start;
    assign hitbox_active = (r_state == c_ST_ACTIVE);
    assign busy          = (r_state == c_ST_WINDUP)   || (r_state == c_ST_ACTIVE) ||
                           (r_state == c_ST_RECOVERY) || (r_state == c_ST_HITSTUN);

endmodule : player_action_fsm
`default_nettype wire

// File: tb/tb_player_action_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_player_action_fsm
//  Purpose  : Self-checking bench for player_action_fsm. Each frame tick
//             pushes the expected post-tick outputs to a scoreboard queue;
//             the entry is popped and compared once the DUT has updated.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_player_action_fsm;

    localparam logic [2:0] c_I  = 3'd0;
    localparam logic [2:0] c_W  = 3'd1;
    localparam logic [2:0] c_B  = 3'd2;
    localparam logic [2:0] c_WU = 3'd3;
    localparam logic [2:0] c_A  = 3'd4;
    localparam logic [2:0] c_R  = 3'd5;
    localparam logic [2:0] c_H  = 3'd6;

    logic       clock = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       btn_left, btn_right, btn_attack, btn_block, hit_in;
    logic [2:0] state;
    logic [1:0] move_dir;
    logic       hitbox_active, attack_start, busy;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [1:0] md;
        logic       hb;
        logic       as;
        logic       bz;
    } exp_t;

    exp_t sb_q[$];

    player_action_fsm dut (
        .clock         (clock),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_attack    (btn_attack),
        .btn_block     (btn_block),
        .hit_in        (hit_in),
        .state         (state),
        .move_dir      (move_dir),
        .hitbox_active (hitbox_active),
        .attack_start  (attack_start),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq({e.tag, ".state"},  32'(state),         32'(e.st));
            check_eq({e.tag, ".dir"},    32'(move_dir),      32'(e.md));
            check_eq({e.tag, ".hitbox"}, 32'(hitbox_active), 32'(e.hb));
            check_eq({e.tag, ".astart"}, 32'(attack_start),  32'(e.as));
            check_eq({e.tag, ".busy"},   32'(busy),          32'(e.bz));
        end
    endtask

    // One frame: record expectation, strobe the tick, compare after the
    // edge, then confirm attack_start has fallen one cycle later.
    task automatic frame(input string tag, input logic [2:0] st, input logic [1:0] md,
                         input logic as);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.md  = md;
        e.hb  = (st == c_A);
        e.as  = as;
        e.bz  = (st == c_WU) || (st == c_A) || (st == c_R) || (st == c_H);
        sb_q.push_back(e);
        @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        compare_head();
        @(negedge clock);
        check_eq({tag, ".astart_drop"}, 32'(attack_start), 32'd0);
        @(negedge clock);
    endtask

    task automatic frames(input string tag, input int n, input logic [2:0] st);
        for (int i = 0; i < n; i++) frame(tag, st, 2'b00, 1'b0);
    endtask

    task automatic press_attack();
        btn_attack = 1'b1;
        repeat (2) @(negedge clock);
        btn_attack = 1'b0;
        @(negedge clock);
    endtask

    task automatic pulse_hit();
        hit_in = 1'b1;
        @(negedge clock);
        hit_in = 1'b0;
        @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".state"},  32'(state),         32'd0);
        check_eq({tag, ".dir"},    32'(move_dir),      32'd0);
        check_eq({tag, ".hitbox"}, 32'(hitbox_active), 32'd0);
        check_eq({tag, ".astart"}, 32'(attack_start),  32'd0);
        check_eq({tag, ".busy"},   32'(busy),          32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_attack = 1'b0;
        btn_block  = 1'b0;
        hit_in     = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clock);
        frame("idle0", c_I, 2'b00, 1'b0);

        // Basic attack: 4 windup, 3 active, 6 recovery frames.
        press_attack();
        frame("s1_wu_entry", c_WU, 2'b00, 1'b1);
        frames("s1_wu", 3, c_WU);
        frames("s1_act", 3, c_A);
        frames("s1_rec", 6, c_R);
        frame("s1_idle", c_I, 2'b00, 1'b0);

        // Hit during ACTIVE: 10 hitstun frames.
        press_attack();
        frame("s2_wu_entry", c_WU, 2'b00, 1'b1);
        frames("s2_wu", 3, c_WU);
        frame("s2_act", c_A, 2'b00, 1'b0);
        pulse_hit();
        frames("s2_hs", 10, c_H);
        frame("s2_idle", c_I, 2'b00, 1'b0);

        // Block absorbs hits.
        btn_block = 1'b1;
        @(negedge clock);
        frame("s3_blk", c_B, 2'b00, 1'b0);
        pulse_hit();
        frame("s3_blk_hit1", c_B, 2'b00, 1'b0);
        pulse_hit();
        frame("s3_blk_hit2", c_B, 2'b00, 1'b0);
        btn_block = 1'b0;
        @(negedge clock);
        frame("s3_idle", c_I, 2'b00, 1'b0);

        // Walk direction.
        btn_left  = 1'b1;
        btn_right = 1'b1;
        @(negedge clock);
        frame("s4_both", c_I, 2'b00, 1'b0);
        btn_right = 1'b0;
        @(negedge clock);
        frame("s4_left", c_W, 2'b10, 1'b0);
        btn_left  = 1'b0;
        btn_right = 1'b1;
        @(negedge clock);
        frame("s4_right", c_W, 2'b01, 1'b0);
        btn_right = 1'b0;
        @(negedge clock);
        frame("s4_idle", c_I, 2'b00, 1'b0);

        // Attack during RECOVERY discarded; second hit extends hitstun to 15.
        press_attack();
        frame("s5_wu_entry", c_WU, 2'b00, 1'b1);
        frames("s5_wu", 3, c_WU);
        frames("s5_act", 3, c_A);
        frame("s5_rec_entry", c_R, 2'b00, 1'b0);
        press_attack();
        frames("s5_rec", 5, c_R);
        frame("s5_idle", c_I, 2'b00, 1'b0);
        frame("s5_no_rewind", c_I, 2'b00, 1'b0);
        pulse_hit();
        frame("s5_hs_entry", c_H, 2'b00, 1'b0);
        frames("s5_hs_a", 4, c_H);
        pulse_hit();
        frame("s5_hs_rehit", c_H, 2'b00, 1'b0);
        frames("s5_hs_b", 9, c_H);
        frame("s5_idle2", c_I, 2'b00, 1'b0);

        // Reset mid-windup with the attack button still held.
        btn_attack = 1'b1;
        repeat (2) @(negedge clock);
        frame("s6_wu_entry", c_WU, 2'b00, 1'b1);
        frame("s6_wu", c_WU, 2'b00, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_outputs("s6_in_reset");
        reset = 1'b0;
        @(negedge clock);
        check_eq("s6_post_reset.astart", 32'(attack_start), 32'd0);
        frame("s6_held1", c_I, 2'b00, 1'b0);
        frame("s6_held2", c_I, 2'b00, 1'b0);
        btn_attack = 1'b0;
        @(negedge clock);
        frame("s6_released", c_I, 2'b00, 1'b0);
        press_attack();
        frame("s6_repress", c_WU, 2'b00, 1'b1);

        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_player_action_fsm
`default_nettype wire

// File: doc/player_action_fsm.md
PLAYER_ACTION_FSM -- requirements
Module: player_action_fsm

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- WINDUP_FRAMES, 4: frames spent in WINDUP.
- ACTIVE_FRAMES, 3: frames hitbox is live.
- RECOVERY_FRAMES, 6: frames in RECOVERY.
- HITSTUN_FRAMES, 10: frames in HITSTUN.
- CNT_W, 4: frame counter width; every *_FRAMES value SHALL be >=1 and <2^CNT_W.
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clock, in, 1: single system clock.
- reset, in, 1: synchronous, active-high reset.
- frame_tick, in, 1: one-cycle game-frame strobe.
- btn_left, btn_right, btn_attack, btn_block, in, 1 each: debounced button levels.
- hit_in, in, 1: one-cycle pulse, opponent hitbox overlapped this player.
- state, out, 3: current action state.
- move_dir, out, 2: {left, right} walk request.
- hitbox_active, out, 1: attack hitbox live.
- attack_start, out, 1: one-cycle pulse on WINDUP entry.
- busy, out, 1: state is WINDUP, ACTIVE, RECOVERY or HITSTUN.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 States SHALL be encoded IDLE=0, WALK=1, BLOCK=2, WINDUP=3, ACTIVE=4, RECOVERY=5, HITSTUN=6; code 7 SHALL return to IDLE on the next frame_tick.
REQ-005 The block SHALL latch a btn_attack rising edge (0 to 1 between consecutive clocks) into attack_pend; attack_pend SHALL clear on every frame_tick, used or not.
REQ-006 The block SHALL latch hit_in into hit_pend; hit_pend SHALL clear on every frame_tick.
REQ-007 Edges or hits arriving in the same cycle as frame_tick SHALL be used on that tick, then cleared.
REQ-008 State transitions SHALL occur only on frame_tick cycles; registered outputs SHALL update on the clock following that tick.
REQ-009 From IDLE, WALK or BLOCK, the next state SHALL follow this priority:
- hit_pend and not in BLOCK: HITSTUN.
- attack_pend: WINDUP.
- btn_block: BLOCK.
- exactly one of btn_left or btn_right: WALK.
- otherwise: IDLE.
REQ-010 A hit received in BLOCK SHALL be absorbed: state remains BLOCK and the hit has no further effect.
REQ-011 On entering a timed state, the frame counter SHALL load N-1, where N is that state's *_FRAMES value.
REQ-012 Each frame_tick in a timed state SHALL decrement the counter; at counter 0 the state SHALL advance WINDUP to ACTIVE, ACTIVE to RECOVERY, and RECOVERY or HITSTUN to IDLE.
REQ-013 hit_pend SHALL pre-empt WINDUP, ACTIVE and RECOVERY into HITSTUN.
REQ-014 A hit_pend during HITSTUN SHALL reload the counter with HITSTUN_FRAMES-1.
REQ-015 attack_pend SHALL be discarded in every timed state.
REQ-016 hitbox_active SHALL be 1 if and only if state is ACTIVE.
REQ-017 move_dir SHALL equal {btn_left, btn_right} sampled at the tick while in WALK, and 2'b00 otherwise.
REQ-018 attack_start SHALL pulse for exactly one cycle on the clock after the tick that enters WINDUP.

Reset
REQ-019 While reset is high: state SHALL be IDLE, counter 0, attack_pend and hit_pend 0, the edge-detect register 0, and all outputs 0.
REQ-020 Reset asserted mid-attack or mid-hitstun SHALL abort the sequence without producing an attack_start pulse.
REQ-021 A button already held when reset deasserts SHALL NOT count as an attack edge.

Structure
REQ-022 State encodings and default frame counts SHALL live in the shared package game_pkg.
REQ-023 Edge detection and the pending latch SHALL be one sub-module, edge_latch, instantiated twice: once for attack, with rising-edge detection, and once for hit, in level-pulse mode.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Attack press between ticks, default parameters: attack_start pulse after the next tick; hitbox_active high for exactly 3 ticks, starting 4 ticks after WINDUP entry; IDLE after a further 6 ticks.
- hit_in during ACTIVE: state is HITSTUN after the next tick, hitbox_active drops, and IDLE follows after 10 ticks.
- btn_block held with hit_in pulsed: state stays BLOCK and never enters HITSTUN.
- btn_left and btn_right held together: state is IDLE with move_dir 00; releasing btn_right gives WALK with move_dir 10.
- Attack pressed during RECOVERY: discarded, no second WINDUP; a second hit_in 5 ticks into HITSTUN extends HITSTUN to 15 ticks in total.
- reset pulsed during WINDUP with btn_attack held: state IDLE and outputs 0; no attack occurs until btn_attack is released and pressed again.
